// File: rtl/wbchk_pkg.sv
// Shared types for the write-back trace checker: FSM state encoding, default widths
// and the trace record layout used at the default parameter set.
package wbchk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } wbchk_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_REGS    = 32;
  localparam int DEF_REG_AW      = $clog2(DEF_NUM_REGS);
  localparam int DEF_CYC_W       = 16;
  localparam int DEF_TRACE_DEPTH = 16;

  typedef struct packed {
    logic [DEF_CYC_W-1:0]  stamp;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } trace_rec_t;

  function automatic logic is_busy(input wbchk_state_e st);
    return (st == ST_RUN) || (st == ST_SCAN);
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous trace FIFO; full/empty come from an extra pointer MSB.
// Simultaneous push and pop always both succeed, even when full.
module wb_trace_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             overflow_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             empty_s;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy decode and push/pop qualification
  always_comb begin
    empty_s   = (wptr_r == rptr_r);
    full_s    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
  end

  // Pointer and sticky overflow state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      overflow_r <= 1'b0;
    end else if (flush) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (do_pop_s)  rptr_r <= rptr_r + (AW+1)'(1);
      if (push && !do_push_s) overflow_r <= 1'b1;
    end
  end

  // Storage array, intentionally not reset; the head is gated by valid instead
  always_ff @(posedge clock) begin
    if (do_push_s && !flush) mem_r[wptr_r[AW-1:0]] <= push_data;
  end

  assign valid     = !empty_s;
  assign head_data = empty_s ? '0 : mem_r[rptr_r[AW-1:0]];
  assign overflow  = overflow_r;

endmodule

// File: rtl/wb_trace_checker.sv
// Run/check harness beside processor + regfile: traces write-backs during RUN, then scans
// every register against an expected memory. WB_CHECK_MASK_EN adds the exp_mask input.
module wb_trace_checker
  import wbchk_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int REG_AW      = $clog2(NUM_REGS),
  parameter int CYC_W       = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CYC_W-1:0]              num_cycles,
  input  logic                          wb_we,
  input  logic [REG_AW-1:0]             wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  output logic                          test_mode,
  output logic [REG_AW-1:0]             scan_reg,
  input  logic [DATA_W-1:0]             scan_data,
  output logic [REG_AW-1:0]             exp_addr,
  input  logic [DATA_W-1:0]             exp_data,
`ifdef WB_CHECK_MASK_EN
  input  logic                          exp_mask,
`endif
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [CYC_W+REG_AW+DATA_W-1:0] trace_data,
  output logic                          trace_overflow,
  output logic                          busy,
  output logic                          done,
  output logic [REG_AW:0]               error_count,
  output logic [REG_AW-1:0]             first_fail_reg,
  output logic                          first_fail_valid
);

  localparam int              TW       = CYC_W + REG_AW + DATA_W;
  localparam logic [REG_AW:0] SCAN_END = (REG_AW+1)'(NUM_REGS);

  wbchk_state_e        state_r;
  wbchk_state_e        state_s;
  logic [CYC_W-1:0]    num_cyc_r;
  logic [CYC_W-1:0]    cyc_cnt_r;
  logic [REG_AW:0]     scan_cnt_r;
  logic                cmp_valid_r;
  logic [REG_AW-1:0]   cmp_idx_r;
  logic [DATA_W-1:0]   scan_q_r;
  logic [REG_AW:0]     err_cnt_r;
  logic [REG_AW-1:0]   ff_reg_r;
  logic                ff_valid_r;
  logic                start_acc_s;
  logic                run_last_s;
  logic                scan_end_s;
  logic                issue_s;
  logic                mismatch_s;
  logic                push_s;
  logic                mask_s;

`ifdef WB_CHECK_MASK_EN
  assign mask_s = exp_mask;
`else
  assign mask_s = 1'b1;
`endif

  // Control decode shared by the FSM and the datapath
  always_comb begin
    start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    run_last_s  = (cyc_cnt_r == (num_cyc_r - CYC_W'(1)));
    scan_end_s  = (scan_cnt_r == SCAN_END);
    issue_s     = (state_r == ST_SCAN) && !scan_end_s;
    mismatch_s  = cmp_valid_r && mask_s && (scan_q_r != exp_data);
    push_s      = (state_r == ST_RUN) && wb_we && (wb_rd != {REG_AW{1'b0}});
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) state_s = (num_cycles == {CYC_W{1'b0}}) ? ST_SCAN : ST_RUN;
        else             state_s = state_r;
      end
      ST_RUN: begin
        if (run_last_s) state_s = ST_SCAN;
        else            state_s = ST_RUN;
      end
      ST_SCAN: begin
        if (scan_end_s) state_s = ST_DONE;
        else            state_s = ST_SCAN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Cycle counter, scan pipeline and result accumulation; start clears prior results
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num_cyc_r   <= '0;
      cyc_cnt_r   <= '0;
      scan_cnt_r  <= '0;
      cmp_valid_r <= 1'b0;
      cmp_idx_r   <= '0;
      scan_q_r    <= '0;
      err_cnt_r   <= '0;
      ff_reg_r    <= '0;
      ff_valid_r  <= 1'b0;
    end else if (start_acc_s) begin
      num_cyc_r   <= num_cycles;
      cyc_cnt_r   <= '0;
      scan_cnt_r  <= '0;
      cmp_valid_r <= 1'b0;
      cmp_idx_r   <= '0;
      scan_q_r    <= '0;
      err_cnt_r   <= '0;
      ff_reg_r    <= '0;
      ff_valid_r  <= 1'b0;
    end else begin
      if (state_r == ST_RUN) cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
      if (issue_s) begin
        scan_cnt_r <= scan_cnt_r + (REG_AW+1)'(1);
        cmp_idx_r  <= scan_cnt_r[REG_AW-1:0];
        scan_q_r   <= scan_data;
      end
      cmp_valid_r <= issue_s;
      if (mismatch_s) begin
        err_cnt_r <= err_cnt_r + (REG_AW+1)'(1);
        if (!ff_valid_r) begin
          ff_reg_r   <= cmp_idx_r;
          ff_valid_r <= 1'b1;
        end
      end
    end
  end

  wb_trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (start_acc_s),
    .push      (push_s),
    .push_data ({cyc_cnt_r, wb_rd, wb_data}),
    .pop       (trace_ready),
    .head_data (trace_data),
    .valid     (trace_valid),
    .overflow  (trace_overflow)
  );

  assign test_mode        = (state_r == ST_SCAN);
  assign scan_reg         = test_mode ? scan_cnt_r[REG_AW-1:0] : {REG_AW{1'b0}};
  assign exp_addr         = scan_reg;
  assign busy             = is_busy(state_r);
  assign done             = (state_r == ST_DONE);
  assign error_count      = err_cnt_r;
  assign first_fail_reg   = ff_reg_r;
  assign first_fail_valid = ff_valid_r;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed self-checking bench for wb_trace_checker: regfile and expected memory are
// bench-side models; scan scenarios come from a vector table, FIFO/reset cases are hand-written.
module tb_wb_trace_checker;
  import wbchk_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CW-1:0]     num_cycles = '0;
  logic              wb_we = 1'b0;
  logic [AW-1:0]     wb_rd = '0;
  logic [DW-1:0]     wb_data = '0;
  logic              test_mode;
  logic [AW-1:0]     scan_reg;
  logic [AW-1:0]     exp_addr;
  logic [DW-1:0]     scan_data;
  logic [DW-1:0]     exp_data = '0;
  logic              exp_mask = 1'b1;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [CW+AW+DW-1:0] trace_data;
  logic              trace_overflow;
  logic              busy;
  logic              done;
  logic [AW:0]       error_count;
  logic [AW-1:0]     first_fail_reg;
  logic              first_fail_valid;

  logic [DW-1:0] regs    [NR];
  logic [DW-1:0] exp_mem [NR];
  logic          mask_mem[NR];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          nc;
    int          bad_a;
    logic [31:0] flip_a;
    int          bad_b;
    logic [31:0] flip_b;
    logic        exp_tm;
    int          exp_err;
    int          exp_ff;
    logic        exp_ffv;
    int          exp_lat;
  } scan_vec_t;

  scan_vec_t rows [5];

  always #5 clock = ~clock;

  assign scan_data = regs[scan_reg];
  always @(posedge clock) begin
    exp_data <= exp_mem[exp_addr];
    exp_mask <= mask_mem[exp_addr];
  end

  wb_trace_checker dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .num_cycles       (num_cycles),
    .wb_we            (wb_we),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .test_mode        (test_mode),
    .scan_reg         (scan_reg),
    .scan_data        (scan_data),
    .exp_addr         (exp_addr),
    .exp_data         (exp_data),
`ifdef WB_CHECK_MASK_EN
    .exp_mask         (exp_mask),
`endif
    .trace_valid      (trace_valid),
    .trace_ready      (trace_ready),
    .trace_data       (trace_data),
    .trace_overflow   (trace_overflow),
    .busy             (busy),
    .done             (done),
    .error_count      (error_count),
    .first_fail_reg   (first_fail_reg),
    .first_fail_valid (first_fail_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int nc);
    num_cycles = CW'(nc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(exp_lat));
  endtask

  function automatic logic [63:0] rec(input int stamp, input int rd, input logic [31:0] data);
    trace_rec_t r;
    r.stamp = CW'(stamp);
    r.rd    = AW'(rd);
    r.data  = data;
    return 64'(r);
  endfunction

  task automatic set_baseline();
    for (int i = 0; i < NR; i++) begin
      exp_mem[i]  = (DW'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
      regs[i]     = exp_mem[i];
      mask_mem[i] = 1'b1;
    end
    exp_mem[7] = 32'd10;
    regs[7]    = 32'd10;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, test_mode, trace_valid, trace_overflow, first_fail_valid}), 64'd0);
    check({tag, "_err"}, 64'(error_count), 64'd0);
    check({tag, "_ffreg"}, 64'(first_fail_reg), 64'd0);
    check({tag, "_scanreg"}, 64'(scan_reg), 64'd0);
    check({tag, "_tdata"}, 64'(trace_data), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{nc:2, bad_a:-1, flip_a:32'h0, bad_b:-1, flip_b:32'h0,
                exp_tm:1'b0, exp_err:0, exp_ff:0, exp_ffv:1'b0, exp_lat:35};
    rows[1] = '{nc:2, bad_a:7, flip_a:32'h1, bad_b:-1, flip_b:32'h0,
                exp_tm:1'b0, exp_err:1, exp_ff:7, exp_ffv:1'b1, exp_lat:35};
    rows[2] = '{nc:1, bad_a:31, flip_a:32'h8000_0000, bad_b:7, flip_b:32'h1,
                exp_tm:1'b0, exp_err:2, exp_ff:7, exp_ffv:1'b1, exp_lat:34};
    rows[3] = '{nc:0, bad_a:-1, flip_a:32'h0, bad_b:-1, flip_b:32'h0,
                exp_tm:1'b1, exp_err:0, exp_ff:0, exp_ffv:1'b0, exp_lat:33};
    rows[4] = '{nc:0, bad_a:31, flip_a:32'h8000_0000, bad_b:0, flip_b:32'h1,
                exp_tm:1'b1, exp_err:2, exp_ff:0, exp_ffv:1'b1, exp_lat:33};

    set_baseline();
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b1;
    tick();

    // Single logged write; r0 and non-RUN writes are ignored
    do_start(4);
    for (int i = 0; i < 4; i++) begin
      wb_we   = (i >= 2);
      wb_rd   = (i == 2) ? AW'(5) : AW'(0);
      wb_data = (i == 2) ? 32'h1234 : 32'd7;
      tick();
      check("t1_valid", 64'(trace_valid), 64'(i >= 2));
    end
    check("t1_test_mode", 64'(test_mode), 64'd1);
    check("t1_head", 64'(trace_data), rec(2, 5, 32'h1234));
    wb_we = 1'b1; wb_rd = AW'(9); wb_data = 32'hDEAD_BEEF;
    wait_done("t1_done_lat", 33);
    tick();
    wb_we = 1'b0;
    check("t1_head_done", 64'(trace_data), rec(2, 5, 32'h1234));
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    check("t1_single_entry", 64'(trace_valid), 64'd0);

    // 20 writes with no consumer: 16 kept, overflow sticky
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      wb_we = 1'b1; wb_rd = AW'(i % 31 + 1); wb_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    wb_we = 1'b0;
    check("t2_overflow", 64'(trace_overflow), 64'd1);
    wait_done("t2_done_lat", 33);
    for (int i = 0; i < 16; i++) begin
      check("t2_entry", 64'(trace_data), rec(i, i % 31 + 1, 32'hA000_0000 + 32'(i)));
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
    end
    check("t2_drained", 64'(trace_valid), 64'd0);
    check("t2_overflow_sticky", 64'(trace_overflow), 64'd1);

    // Push+pop while full both succeed; the next push when full is dropped
    do_start(18);
    check("t2b_flush", 64'({trace_valid, trace_overflow}), 64'd0);
    for (int i = 0; i < 18; i++) begin
      wb_we = 1'b1; wb_rd = AW'(3); wb_data = 32'(i);
      trace_ready = (i == 16);
      tick();
      if (i == 16) check("t2b_no_ovf_on_pushpop", 64'(trace_overflow), 64'd0);
    end
    wb_we = 1'b0; trace_ready = 1'b0;
    check("t2b_overflow", 64'(trace_overflow), 64'd1);
    for (int j = 0; j < 16; j++) begin
      check("t2b_entry", 64'(trace_data), rec(j + 1, 3, 32'(j + 1)));
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
    end
    check("t2b_drained", 64'(trace_valid), 64'd0);
    wait_done("t2b_done_lat", 17);

    // Scan scenarios from the vector table
    for (int r = 0; r < 5; r++) begin
      set_baseline();
      if (rows[r].bad_a >= 0) regs[rows[r].bad_a] = exp_mem[rows[r].bad_a] ^ rows[r].flip_a;
      if (rows[r].bad_b >= 0) regs[rows[r].bad_b] = exp_mem[rows[r].bad_b] ^ rows[r].flip_b;
      do_start(rows[r].nc);
      check("scan_tm_after_start", 64'(test_mode), 64'(rows[r].exp_tm));
      check("scan_cleared", 64'({busy, done, first_fail_valid, error_count}), 64'({1'b1, 1'b0, 1'b0, 6'd0}));
      wait_done("scan_done_lat", rows[r].exp_lat);
      check("scan_err", 64'(error_count), 64'(rows[r].exp_err));
      check("scan_ffreg", 64'(first_fail_reg), 64'(rows[r].exp_ff));
      check("scan_ffvalid", 64'(first_fail_valid), 64'(rows[r].exp_ffv));
      check("scan_end_ctl", 64'({busy, test_mode, done}), 64'd1);
    end
    check("scan_fifo_empty", 64'(trace_valid), 64'd0);

    // Asynchronous reset in the middle of SCAN, then a clean rerun
    set_baseline();
    regs[2] = exp_mem[2] ^ 32'h1;
    do_start(3);
    wb_we = 1'b1; wb_rd = AW'(4); wb_data = 32'h55;
    tick();
    wb_we = 1'b0;
    tick();
    tick();
    repeat (10) tick();
    check("t5_pre_err", 64'(error_count), 64'd1);
    check("t5_pre_valid", 64'(trace_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_zero("t5_async");
    #10 reset = 1'b1;
    @(posedge clock);
    #1;
    regs[2] = exp_mem[2];
    do_start(3);
    wait_done("t5_rerun_lat", 36);
    check("t5_rerun_err", 64'(error_count), 64'd0);
    check("t5_rerun_fifo", 64'(trace_valid), 64'd0);

`ifdef WB_CHECK_MASK_EN
    // Masked register never counts as a failure
    set_baseline();
    regs[29] = exp_mem[29] ^ 32'h00FF_0000;
    mask_mem[29] = 1'b0;
    do_start(0);
    wait_done("t6_masked_lat", 33);
    check("t6_masked_err", 64'(error_count), 64'd0);
    mask_mem[29] = 1'b1;
    do_start(0);
    wait_done("t6_unmasked_lat", 33);
    check("t6_unmasked_err", 64'(error_count), 64'd1);
    check("t6_unmasked_ff", 64'(first_fail_reg), 64'd29);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
